brick_tracker: RTL and testbench

BRICK_TRACKER -- requirements
Module: brick_tracker

---
 rtl/brick_tracker.sv | 169 ++++++++++++++++
 tb/tb_brick_tracker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/brick_tracker.sv
`default_nettype none
// ============================================================================
// Module      : brick_tracker
// Description : Per-frame ball/brick collision pass over a 5x2 brick wall,
//               with brick clearing, bounce direction and saturating score.
// Revision    : 1.0 - initial release
// ============================================================================
module brick_tracker #(
  parameter int BALL_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic       level_restart,
  output logic [9:0] alive,
  output logic       hit_valid,
  output logic [3:0] hit_index,
  output logic       bounce_x,
  output logic       bounce_y,
  output logic [7:0] score,
  output logic       busy,
  output logic       all_cleared
);

  localparam logic [10:0] c_ball      = 11'(BALL_SIZE);
  localparam logic [10:0] c_ball_half = 11'(BALL_SIZE / 2);
  localparam logic [10:0] c_brick_w   = 11'd124;
  localparam logic [10:0] c_brick_h   = 11'd20;
  localparam logic [9:0]  c_all_alive = 10'h3FF;
  localparam logic [3:0]  c_last_idx  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCAN    = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_scan_idx;
  logic [9:0]  r_bx;
  logic [9:0]  r_by;
  logic        r_hit_found;
  logic [3:0]  r_hit_k;
  logic [9:0]  r_alive;
  logic        r_hit_valid;
  logic [3:0]  r_hit_index;
  logic        r_bounce_x;
  logic        r_bounce_y;
  logic [7:0]  r_score;

  // Bricks 0..4 form the top row, 5..9 the second row.
  function automatic logic [10:0] brick_left(input logic [3:0] idx);
    logic [3:0] col;
    col = (idx >= 4'd5) ? (idx - 4'd5) : idx;
    return {1'b0, col[2:0], 7'd0};
  endfunction

  function automatic logic [10:0] brick_top(input logic [3:0] idx);
    return (idx >= 4'd5) ? 11'd24 : 11'd0;
  endfunction

  logic [10:0] w_left;
  logic [10:0] w_top;
  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic        w_overlap;
  logic [10:0] w_hit_top;
  logic [10:0] w_center_y;
  logic        w_side_hit;

  always_comb begin
    w_left     = brick_left(r_scan_idx);
    w_top      = brick_top(r_scan_idx);
    w_bx       = {1'b0, r_bx};
    w_by       = {1'b0, r_by};
    w_overlap  = r_alive[r_scan_idx]
                 && (w_bx < w_left + c_brick_w) && (w_left < w_bx + c_ball)
                 && (w_by < w_top + c_brick_h)  && (w_top < w_by + c_ball);
    w_hit_top  = brick_top(r_hit_k);
    w_center_y = w_by + c_ball_half;
    // Ball centre level with the brick face means it struck a side.
    w_side_hit = (w_center_y >= w_hit_top) && (w_center_y < w_hit_top + c_brick_h);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (frame_tick) w_state_next = S_SCAN;
      S_SCAN:    if (r_scan_idx == c_last_idx) w_state_next = S_RESOLVE;
      S_RESOLVE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (level_restart) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_idx  <= 4'd0;
      r_bx        <= 10'd0;
      r_by        <= 10'd0;
      r_hit_found <= 1'b0;
      r_hit_k     <= 4'd0;
      r_alive     <= c_all_alive;
      r_hit_valid <= 1'b0;
      r_hit_index <= 4'd0;
      r_bounce_x  <= 1'b0;
      r_bounce_y  <= 1'b0;
      r_score     <= 8'd0;
    end else begin
      r_hit_valid <= 1'b0;
      if (level_restart) begin
        r_alive     <= c_all_alive;
        r_hit_found <= 1'b0;
        r_scan_idx  <= 4'd0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (frame_tick) begin
              r_bx        <= ball_x;
              r_by        <= ball_y;
              r_hit_found <= 1'b0;
              r_scan_idx  <= 4'd0;
            end
          end
          S_SCAN: begin
            if (w_overlap && !r_hit_found) begin
              r_hit_found <= 1'b1;
              r_hit_k     <= r_scan_idx;
            end
            r_scan_idx <= r_scan_idx + 4'd1;
          end
          S_RESOLVE: begin
            if (r_hit_found) begin
              r_alive[r_hit_k] <= 1'b0;
              r_hit_index      <= r_hit_k;
              r_hit_valid      <= 1'b1;
              r_bounce_x       <= w_side_hit;
              r_bounce_y       <= !w_side_hit;
              if (r_score != 8'hFF) r_score <= r_score + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign alive       = r_alive;
  assign hit_valid   = r_hit_valid;
  assign hit_index   = r_hit_index;
  assign bounce_x    = r_bounce_x;
  assign bounce_y    = r_bounce_y;
  assign score       = r_score;
  assign busy        = (r_state != S_IDLE);
  assign all_cleared = (r_alive == 10'd0);

endmodule
`default_nettype wire

// File: tb/tb_brick_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_brick_tracker
// Description : Directed self-checking bench for brick_tracker (BALL_SIZE 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_brick_tracker;

  logic       clk;
  logic       rst_n;
  logic       frame_tick;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       level_restart;
  logic [9:0] alive;
  logic       hit_valid;
  logic [3:0] hit_index;
  logic       bounce_x;
  logic       bounce_y;
  logic [7:0] score;
  logic       busy;
  logic       all_cleared;

  int n_checks = 0;
  int n_errors = 0;
  int bc;
  int hv;
  int exp_score;

  brick_tracker #(.BALL_SIZE(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .ball_x       (ball_x),
    .ball_y       (ball_y),
    .level_restart(level_restart),
    .alive        (alive),
    .hit_valid    (hit_valid),
    .hit_index    (hit_index),
    .bounce_x     (bounce_x),
    .bounce_y     (bounce_y),
    .score        (score),
    .busy         (busy),
    .all_cleared  (all_cleared)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic restart();
    @(negedge clk); level_restart = 1'b1;
    @(negedge clk); level_restart = 1'b0;
  endtask

  // Runs one pass; returns busy cycle count and number of hit_valid cycles.
  task automatic do_pass(input logic [9:0] x, input logic [9:0] y,
                         output int busy_cyc, output int hv_cyc);
    @(negedge clk); ball_x = x; ball_y = y; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    busy_cyc = 0;
    hv_cyc   = 0;
    for (int i = 0; i < 30; i++) begin
      if (hit_valid) hv_cyc++;
      if (!busy) break;
      busy_cyc++;
      @(negedge clk);
    end
    @(negedge clk);
    if (hit_valid) hv_cyc++;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; level_restart = 1'b0;
    ball_x = 10'd0; ball_y = 10'd0;
    repeat (3) @(negedge clk);
    check("rst_low_alive", alive, 10'h3FF);
    check("rst_low_hidx", hit_index, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_alive", alive, 10'h3FF);
    check("rst_score", score, 8'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_cleared", all_cleared, 1'b0);
    check("rst_hv", hit_valid, 1'b0);
    check("rst_bounce", {bounce_x, bounce_y}, 2'b00);

    // Bottom hit on brick 6
    do_pass(10'd200, 10'd40, bc, hv);
    check("bot_busy_cyc", bc, 11);
    check("bot_hv_cyc", hv, 1);
    check("bot_hidx", hit_index, 4'd6);
    check("bot_alive", alive, 10'h3BF);
    check("bot_score", score, 8'd1);
    check("bot_bounce", {bounce_x, bounce_y}, 2'b01);

    // Repeat on cleared brick, then a plain miss
    do_pass(10'd200, 10'd40, bc, hv);
    check("rep_busy_cyc", bc, 11);
    check("rep_hv_cyc", hv, 0);
    check("rep_alive", alive, 10'h3BF);
    check("rep_score", score, 8'd1);
    check("rep_hidx_held", hit_index, 4'd6);
    do_pass(10'd100, 10'd200, bc, hv);
    check("miss_busy_cyc", bc, 11);
    check("miss_hv_cyc", hv, 0);
    check("miss_alive", alive, 10'h3BF);

    // Restart keeps score; straddle hits lowest index first
    restart();
    check("rs_alive", alive, 10'h3FF);
    check("rs_score", score, 8'd1);
    do_pass(10'd250, 10'd40, bc, hv);
    check("str1_hidx", hit_index, 4'd6);
    check("str1_alive", alive, 10'h3BF);
    do_pass(10'd250, 10'd40, bc, hv);
    check("str2_hidx", hit_index, 4'd7);
    check("str2_alive", alive, 10'h33F);
    check("str2_score", score, 8'd3);

    // Half-open edges: (252,44) touches nothing
    do_pass(10'd252, 10'd44, bc, hv);
    check("edge_hv_cyc", hv, 0);
    check("edge_alive", alive, 10'h33F);
    // (251,43) overlaps only bricks 6 and 7, both dead
    do_pass(10'd251, 10'd43, bc, hv);
    check("dead_hv_cyc", hv, 0);
    // Far corner, no wrap
    do_pass(10'd639, 10'd479, bc, hv);
    check("corner_hv_cyc", hv, 0);

    // Side hit on brick 0 (centre y 9 within [0,20))
    do_pass(10'd10, 10'd5, bc, hv);
    check("side_hidx", hit_index, 4'd0);
    check("side_bounce", {bounce_x, bounce_y}, 2'b10);
    check("side_alive", alive, 10'h33E);
    check("side_score", score, 8'd4);

    // Abort at E5 of a pass that would hit brick 0
    restart();
    @(negedge clk); ball_x = 10'd0; ball_y = 10'd0; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    level_restart = 1'b1;
    @(negedge clk); level_restart = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_alive", alive, 10'h3FF);
    hv = 0;
    for (int i = 0; i < 12; i++) begin
      if (hit_valid) hv++;
      @(negedge clk);
    end
    check("abort_hv", hv, 0);
    check("abort_score", score, 8'd4);

    // Simultaneous tick and restart: restart wins
    @(negedge clk); ball_x = 10'd0; ball_y = 10'd0; frame_tick = 1'b1; level_restart = 1'b1;
    @(negedge clk); frame_tick = 1'b0; level_restart = 1'b0;
    check("simul_busy", busy, 1'b0);

    // Miss pass with position change and extra tick while busy
    @(negedge clk); ball_x = 10'd100; ball_y = 10'd200; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); ball_x = 10'd0; ball_y = 10'd0; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    hv = 0; bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (hit_valid) hv++;
      if (busy) bc++;
      @(negedge clk);
    end
    check("ign_busy_cyc", bc, 9);
    check("ign_hv", hv, 0);
    check("ign_alive", alive, 10'h3FF);

    // Clear every brick
    for (int i = 0; i < 10; i++) begin
      do_pass(10'((i % 5) * 128 + 10), 10'((i / 5) * 24 + 5), bc, hv);
      check($sformatf("clr%0d_hidx", i), hit_index, 32'(i));
    end
    check("clr_alive", alive, 10'h000);
    check("clr_all", all_cleared, 1'b1);
    check("clr_score", score, 8'd14);
    do_pass(10'd0, 10'd0, bc, hv);
    check("clr_pass_busy", bc, 11);
    check("clr_pass_hv", hv, 0);

    // Async reset mid-pass
    restart();
    @(negedge clk); ball_x = 10'd0; ball_y = 10'd0; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_alive", alive, 10'h3FF);
    check("mid_rst_score", score, 8'd0);
    @(negedge clk); rst_n = 1'b1;

    // Saturate score
    exp_score = 0;
    for (int i = 0; i < 256; i++) begin
      restart();
      do_pass(10'd10, 10'd5, bc, hv);
      if (exp_score < 255) exp_score++;
    end
    check("sat_score", score, 32'(exp_score));
    restart();
    do_pass(10'd10, 10'd5, bc, hv);
    check("sat_hv", hv, 1);
    check("sat_hold", score, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
